// File: rtl/mc_pkg.sv
// Shared types and encodings for the RV32I multi-cycle controller.
package mc_pkg;

    typedef enum logic [3:0] {
        IDLE,
        FETCH,
        DECODE,
        MEMADR,
        MEMREAD,
        MEMWB,
        MEMWRITE,
        EXECR,
        EXECI,
        ALUWB,
        BRANCH,
        JAL,
        TRAP
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_RS1   = 2'b01;
    localparam logic [1:0] SRCA_OLDPC = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;

    localparam logic [1:0] WB_ALUOUT = 2'b00;
    localparam logic [1:0] WB_MDR    = 2'b01;
    localparam logic [1:0] WB_PC     = 2'b10;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

endpackage

// File: rtl/mc_wait_timer.sv
// Counts consecutive not-ready cycles of a memory request and flags the
// cycle in which the TIMEOUT-th wait would complete (TIMEOUT = 0 disables).
module mc_wait_timer #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic waiting,
    input  logic mem_ready,
    output logic expired_c
);

    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CNT_W-1:0] cnt;

    // Ready beats the timeout when both land in the same cycle.
    assign expired_c = (TIMEOUT != 0) && waiting && !mem_ready
                       && (cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (!waiting || mem_ready || expired_c) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle control FSM: sequences the shared memory port and ALU per
// instruction, with req/ready handshake, stall timeout, sticky trap, instret.
module multicycle_controller
    import mc_pkg::*;
#(
    parameter int unsigned TIMEOUT   = 255,
    parameter int unsigned COUNTER_W = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [6:0]           opcode,
    input  logic                 mem_ready,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic                 i_or_d,
    output logic                 ir_write,
    output logic                 pc_write,
    output logic                 branch,
    output logic                 pc_src,
    output logic [1:0]           alu_src_a,
    output logic [1:0]           alu_src_b,
    output logic [1:0]           alu_op,
    output logic                 reg_write,
    output logic [1:0]           mem_to_reg,
    output logic                 trap,
    output logic [1:0]           trap_cause,
    output logic [COUNTER_W-1:0] instret
);

    state_t     state;
    state_t     state_nxt;
    logic [1:0] cause_nxt;
    logic       retire_c;
    logic       waiting_c;
    logic       expired_c;

    assign waiting_c = (state == FETCH) || (state == MEMREAD) || (state == MEMWRITE);

    mc_wait_timer #(
        .TIMEOUT(TIMEOUT)
    ) u_wait_timer (
        .clk      (clk),
        .reset    (reset),
        .waiting  (waiting_c),
        .mem_ready(mem_ready),
        .expired_c(expired_c)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            trap_cause <= CAUSE_NONE;
            instret    <= '0;
        end else begin
            state      <= state_nxt;
            trap_cause <= cause_nxt;
            if (retire_c) begin
                instret <= instret + COUNTER_W'(1);
            end
        end
    end

    // Next state and decoded control outputs.
    always_comb begin
        state_nxt  = state;
        cause_nxt  = trap_cause;
        retire_c   = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        i_or_d     = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        branch     = 1'b0;
        pc_src     = 1'b0;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_RS2;
        alu_op     = ALU_ADD;
        reg_write  = 1'b0;
        mem_to_reg = WB_ALUOUT;
        trap       = 1'b0;

        unique case (state)
            IDLE: state_nxt = FETCH;
            FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = SRCB_FOUR;
                if (mem_ready) begin
                    ir_write  = 1'b1;
                    pc_write  = 1'b1;
                    state_nxt = DECODE;
                end else if (expired_c) begin
                    state_nxt = TRAP;
                    cause_nxt = CAUSE_TIMEOUT;
                end
            end
            DECODE: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
                case (opcode)
                    OP_LOAD, OP_STORE: state_nxt = MEMADR;
                    OP_RTYPE:          state_nxt = EXECR;
                    OP_ITYPE:          state_nxt = EXECI;
                    OP_BRANCH:         state_nxt = BRANCH;
                    OP_JAL:            state_nxt = JAL;
                    default: begin
                        state_nxt = TRAP;
                        cause_nxt = CAUSE_ILLEGAL;
                    end
                endcase
            end
            MEMADR: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                state_nxt = (opcode == OP_STORE) ? MEMWRITE : MEMREAD;
            end
            MEMREAD: begin
                mem_req = 1'b1;
                i_or_d  = 1'b1;
                if (mem_ready) begin
                    state_nxt = MEMWB;
                end else if (expired_c) begin
                    state_nxt = TRAP;
                    cause_nxt = CAUSE_TIMEOUT;
                end
            end
            MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = WB_MDR;
                state_nxt  = FETCH;
                retire_c   = 1'b1;
            end
            MEMWRITE: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                i_or_d  = 1'b1;
                if (mem_ready) begin
                    state_nxt = FETCH;
                    retire_c  = 1'b1;
                end else if (expired_c) begin
                    state_nxt = TRAP;
                    cause_nxt = CAUSE_TIMEOUT;
                end
            end
            EXECR: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_RS2;
                alu_op    = ALU_FUNCT;
                state_nxt = ALUWB;
            end
            EXECI: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                alu_op    = ALU_FUNCT;
                state_nxt = ALUWB;
            end
            ALUWB: begin
                reg_write = 1'b1;
                state_nxt = FETCH;
                retire_c  = 1'b1;
            end
            BRANCH: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_RS2;
                alu_op    = ALU_SUB;
                branch    = 1'b1;
                pc_src    = 1'b1;
                state_nxt = FETCH;
                retire_c  = 1'b1;
            end
            JAL: begin
                pc_write   = 1'b1;
                pc_src     = 1'b1;
                reg_write  = 1'b1;
                mem_to_reg = WB_PC;
                state_nxt  = FETCH;
                retire_c   = 1'b1;
            end
            TRAP: trap = 1'b1;
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller (TIMEOUT=4, COUNTER_W=4).
module tb_multicycle_controller;
    import mc_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] opcode;
    logic       mem_ready;
    logic       mem_req, mem_we, i_or_d, ir_write, pc_write, branch, pc_src;
    logic [1:0] alu_src_a, alu_src_b, alu_op, mem_to_reg, trap_cause;
    logic       reg_write, trap;
    logic [3:0] instret;
    logic [18:0] ctl;

    int checks   = 0;
    int failures = 0;

    multicycle_controller #(
        .TIMEOUT  (4),
        .COUNTER_W(4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .opcode    (opcode),
        .mem_ready (mem_ready),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .i_or_d    (i_or_d),
        .ir_write  (ir_write),
        .pc_write  (pc_write),
        .branch    (branch),
        .pc_src    (pc_src),
        .alu_src_a (alu_src_a),
        .alu_src_b (alu_src_b),
        .alu_op    (alu_op),
        .reg_write (reg_write),
        .mem_to_reg(mem_to_reg),
        .trap      (trap),
        .trap_cause(trap_cause),
        .instret   (instret)
    );

    always #5 clk = ~clk;

    assign ctl = {mem_req, mem_we, i_or_d, ir_write, pc_write, branch, pc_src,
                  alu_src_a, alu_src_b, alu_op, reg_write, mem_to_reg, trap, trap_cause};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_state(input string tag, input state_t s);
        check(tag, 32'(dut.state), 32'(s));
    endtask

    // Asserts reset away from the edge and releases it after one edge.
    task automatic do_reset();
        reset = 1'b1;
        #1;
        chk_state("rst_state", IDLE);
        check("rst_ctl", 32'(ctl), 32'd0);
        check("rst_instret", 32'(instret), 32'd0);
        tick();
        reset = 1'b0;
    endtask

    state_t tr1 [5]     = '{FETCH, DECODE, EXECR, ALUWB, FETCH};
    state_t ld_st [10]  = '{FETCH, FETCH, FETCH, FETCH, DECODE, MEMADR,
                            MEMREAD, MEMREAD, MEMREAD, MEMWB};
    logic   ld_rdy [10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

    initial begin
        int bad;
        int ir_pulses;

        // R-type with memory always ready
        reset     = 1'b1;
        opcode    = OP_RTYPE;
        mem_ready = 1'b1;
        #2;
        chk_state("por_state", IDLE);
        check("por_ctl", 32'(ctl), 32'd0);
        check("por_instret", 32'(instret), 32'd0);
        tick();
        reset = 1'b0;
        #1;
        check("idle_ctl", 32'(ctl), 32'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_state($sformatf("r_trace%0d", i), tr1[i]);
            check($sformatf("r_regw%0d", i), 32'(reg_write), (i == 3) ? 32'd1 : 32'd0);
            if (i == 0) begin
                check("fetch_irw", 32'(ir_write), 32'd1);
                check("fetch_srcb", 32'(alu_src_b), 32'd1);
            end
            if (i == 2) check("execr_aluop", 32'(alu_op), 32'd2);
        end
        check("r_instret", 32'(instret), 32'd1);

        // Load with 3 FETCH waits and 2 MEMREAD waits: 10 cycles FETCH->FETCH
        opcode    = OP_LOAD;
        ir_pulses = 0;
        for (int c = 0; c < 10; c++) begin
            if (c > 0) tick();
            mem_ready = ld_rdy[c];
            #1;
            chk_state($sformatf("ld_state%0d", c), ld_st[c]);
            ir_pulses += int'(ir_write);
            if (!ld_rdy[c]) begin
                check($sformatf("ld_req%0d", c), 32'(mem_req), 32'd1);
                check($sformatf("ld_iord%0d", c), 32'(i_or_d),
                      (ld_st[c] == MEMREAD) ? 32'd1 : 32'd0);
            end
            if (c == 9) check("memwb_m2r", 32'({reg_write, mem_to_reg}), 32'b101);
        end
        tick();
        chk_state("ld_end", FETCH);
        check("ld_irw_pulses", 32'(ir_pulses), 32'd1);
        check("ld_instret", 32'(instret), 32'd2);

        // Illegal opcode traps and holds
        mem_ready = 1'b1;
        opcode    = 7'b1111111;
        tick();
        tick();
        chk_state("ill_state", TRAP);
        check("ill_trap", 32'(trap), 32'd1);
        check("ill_cause", 32'(trap_cause), 32'd1);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (mem_req !== 1'b0 || trap !== 1'b1 || trap_cause !== 2'b01) bad++;
        end
        check("ill_hold", 32'(bad), 32'd0);
        check("ill_instret", 32'(instret), 32'd2);
        do_reset();
        check("ill_rst_trap", 32'(trap), 32'd0);

        // Timeout: 4 waits in FETCH -> TRAP cause 10
        mem_ready = 1'b0;
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (dut.state !== FETCH || mem_req !== 1'b1 || i_or_d !== 1'b0) bad++;
        end
        check("to_waiting", 32'(bad), 32'd0);
        tick();
        chk_state("to_state", TRAP);
        check("to_cause", 32'(trap_cause), 32'd2);
        check("to_req", 32'(mem_req), 32'd0);
        do_reset();

        // Ready on the 4th wait cycle wins; then I-type completes
        opcode = OP_ITYPE;
        for (int i = 0; i < 4; i++) tick();
        mem_ready = 1'b1;
        tick();
        chk_state("rw_state", DECODE);
        check("rw_trap", 32'(trap), 32'd0);
        tick();
        chk_state("execi_state", EXECI);
        check("execi_srcs", 32'({alu_src_a, alu_src_b, alu_op}), 32'b011010);
        tick();
        tick();
        chk_state("i_end", FETCH);
        check("i_instret", 32'(instret), 32'd1);

        // Branch, 3 cycles
        opcode = OP_BRANCH;
        tick();
        tick();
        check("br_ctl", 32'({branch, pc_src, alu_op, alu_src_a, alu_src_b}), 32'b11010100);
        tick();
        chk_state("br_end", FETCH);
        check("br_instret", 32'(instret), 32'd2);

        // 15 JALs -> 17 retires total, 4-bit counter wraps to 1
        opcode = OP_JAL;
        bad = 0;
        for (int j = 0; j < 15; j++) begin
            tick();
            tick();
            if (dut.state !== JAL || {pc_write, pc_src, reg_write, mem_to_reg} !== 5'b11110) bad++;
            tick();
            if (j == 13) check("jal_wrap0", 32'(instret), 32'd0);
        end
        check("jal_ctl", 32'(bad), 32'd0);
        check("jal_wrap1", 32'(instret), 32'd1);

        // Store, 4 cycles with zero wait
        opcode = OP_STORE;
        for (int i = 0; i < 4; i++) tick();
        chk_state("st_end", FETCH);
        check("st_instret", 32'(instret), 32'd2);

        // Reset in the middle of a stalled MEMWRITE
        tick();
        tick();
        tick();
        mem_ready = 1'b0;
        #1;
        chk_state("st2_state", MEMWRITE);
        check("st2_req", 32'({mem_req, mem_we, i_or_d}), 32'b111);
        tick();
        #2;
        reset = 1'b1;
        #1;
        check("st2_rst_req", 32'({mem_req, mem_we}), 32'd0);
        check("st2_rst_instret", 32'(instret), 32'd0);
        chk_state("st2_rst_state", IDLE);
        reset = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
